// File: rtl/mem_access_seq.sv
// Byte-serial memory access sequencer: big-endian word/halfword/byte reads and writes
// over an 8-bit synchronous memory. Optional sign extension via MEM_SEQ_SIGN_EXT_EN.
module mem_access_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, WR, RD, RDRAIN} state_t;

  state_t      state_q;
  logic [1:0]  rem_q;
  logic [1:0]  size_q;
  logic        first_q;
  logic [23:0] wsh_q;
  logic [23:0] rsh_q;
  logic [7:0]  mem_addr_q;
  logic [7:0]  mem_wdata_q;
  logic        mem_we_q;
  logic [31:0] rdata_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;

  logic        req_word;
  logic        req_half;
  logic        aligned_d;
  logic [1:0]  len_m1_d;
  logic [31:0] wsh_init_d;
  logic [31:0] rd_full_d;
  logic        ext_bit_d;
  logic [31:0] rdata_d;

`ifdef MEM_SEQ_SIGN_EXT_EN
  logic sign_q;
`else
  logic unused_sign;
  assign unused_sign = sign;
`endif

  always_comb begin
    req_word   = (size == 2'b00);
    req_half   = (size == 2'b01);
    aligned_d  = req_word ? (addr[1:0] == 2'b00) : (req_half ? !addr[0] : 1'b1);
    len_m1_d   = req_word ? 2'd3 : (req_half ? 2'd1 : 2'd0);
    // Left-justify the bytes to send so the MSB byte always leaves first.
    wsh_init_d = req_word ? wdata : (req_half ? {wdata[15:0], 16'h0000} : {wdata[7:0], 24'h000000});
    rd_full_d  = {rsh_q, mem_rdata};
`ifdef MEM_SEQ_SIGN_EXT_EN
    ext_bit_d  = sign_q & ((size_q == 2'b01) ? rd_full_d[15] : rd_full_d[7]);
`else
    ext_bit_d  = 1'b0;
`endif
    case (size_q)
      2'b00:   rdata_d = rd_full_d;
      2'b01:   rdata_d = {{16{ext_bit_d}}, rd_full_d[15:0]};
      default: rdata_d = {{24{ext_bit_d}}, rd_full_d[7:0]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      size_q      <= '0;
      first_q     <= 1'b0;
      wsh_q       <= '0;
      rsh_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef MEM_SEQ_SIGN_EXT_EN
      sign_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (!aligned_d) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              mem_addr_q <= addr;
              if (we) mem_wdata_q <= wsh_init_d[31:24];
              mem_we_q   <= we;
              busy_q     <= 1'b1;
              rem_q      <= len_m1_d;
              size_q     <= req_word ? 2'b00 : (req_half ? 2'b01 : 2'b10);
              wsh_q      <= wsh_init_d[23:0];
              rsh_q      <= '0;
              first_q    <= 1'b1;
`ifdef MEM_SEQ_SIGN_EXT_EN
              sign_q     <= sign;
`endif
              state_q    <= we ? WR : RD;
            end
          end
        end
        WR: begin
          if (rem_q == 2'd0) begin
            mem_we_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= IDLE;
          end else begin
            mem_addr_q  <= mem_addr_q + 8'd1;
            mem_wdata_q <= wsh_q[23:16];
            wsh_q       <= {wsh_q[15:0], 8'h00};
            rem_q       <= rem_q - 2'd1;
          end
        end
        RD: begin
          // Memory data lags the address by one cycle, so skip capture on the first edge.
          first_q <= 1'b0;
          if (!first_q) rsh_q <= {rsh_q[15:0], mem_rdata};
          if (rem_q == 2'd0) begin
            state_q <= RDRAIN;
          end else begin
            mem_addr_q <= mem_addr_q + 8'd1;
            rem_q      <= rem_q - 2'd1;
          end
        end
        RDRAIN: begin
          rdata_q <= rdata_d;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
